// File: rtl/b_bop_lut_infer.sv
// b_bop_lut_infer: recovers the 8-entry bop LUT from observed (rd, rs1, rs2, result) tuples,
// scanning LANES bits per cycle and accumulating known entries and conflicts until clear.
module b_bop_lut_infer #(
    parameter int LANES = 8
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rd,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] result,
    output logic [7:0]  lut,
    output logic [7:0]  lut_known,
    output logic        conflict,
    output logic        busy,
    output logic        complete
);
    localparam int NS = 32 / LANES;
    localparam logic [4:0] LAST = 5'(NS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q, state_d;
    logic [31:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d;
    logic [4:0]  count_q, count_d;
    logic [7:0]  lut_q, lut_d, known_q, known_d;
    logic        conflict_q, conflict_d;
    logic [2:0]  idx;

    // Operands shift down by LANES each scan cycle, so the current slice is always in the low bits.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        res_d      = res_q;
        count_d    = count_q;
        lut_d      = lut_q;
        known_d    = known_q;
        conflict_d = conflict_q;
        idx        = '0;
        if (clear) begin
            state_d    = IDLE;
            count_d    = '0;
            lut_d      = '0;
            known_d    = '0;
            conflict_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (in_valid) begin
                rd_d    = rd;
                rs1_d   = rs1;
                rs2_d   = rs2;
                res_d   = result;
                count_d = '0;
                state_d = SCAN;
            end
        end else begin
            // Lanes walk upward, so the lowest lane claims a new index and later lanes compare against it.
            for (int i = 0; i < LANES; i++) begin
                idx = {rd_q[i], rs2_q[i], rs1_q[i]};
                if (known_d[idx]) begin
                    conflict_d = conflict_d | (lut_d[idx] != res_q[i]);
                end else begin
                    lut_d[idx]   = res_q[i];
                    known_d[idx] = 1'b1;
                end
            end
            rd_d    = rd_q >> LANES;
            rs1_d   = rs1_q >> LANES;
            rs2_d   = rs2_q >> LANES;
            res_d   = res_q >> LANES;
            count_d = count_q + 5'd1;
            state_d = (count_q == LAST) ? IDLE : SCAN;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            res_q      <= '0;
            count_q    <= '0;
            lut_q      <= '0;
            known_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            res_q      <= res_d;
            count_q    <= count_d;
            lut_q      <= lut_d;
            known_q    <= known_d;
            conflict_q <= conflict_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !clear;
    assign busy      = (state_q == SCAN);
    assign lut       = lut_q;
    assign lut_known = known_q;
    assign conflict  = conflict_q;
    assign complete  = &known_q;
endmodule
